// File: rtl/uart_alu_interface_if.sv
// Byte-stream and ALU operand bundle between the UART side, the command front end and the ALU.
// The slave modport is the front end; the master modport is whatever drives RX bytes and the ALU result.
interface uart_alu_interface_if #(
    parameter int NB_DATA = 8,
    parameter int NB_OPS  = 6
);
    logic [NB_DATA-1:0] i_rx_data;
    logic               i_rx_valid;
    logic [NB_DATA-1:0] i_res;
    logic [NB_DATA-1:0] o_data_a;
    logic [NB_DATA-1:0] o_data_b;
    logic [NB_OPS-1:0]  o_ops;
    logic [NB_DATA-1:0] o_tx_data;
    logic               o_tx_valid;

    modport master (
        output i_rx_data, i_rx_valid, i_res,
        input  o_data_a, o_data_b, o_ops, o_tx_data, o_tx_valid
    );

    modport slave (
        input  i_rx_data, i_rx_valid, i_res,
        output o_data_a, o_data_b, o_ops, o_tx_data, o_tx_valid
    );
endinterface

// File: rtl/uart_alu_interface.sv
// Two-byte command decoder: loads ALU operands/opcode from the RX stream and
// hands the ALU result to TX as a one-cycle strobe on a 0xFF command.
module uart_alu_interface #(
    parameter int                NB_DATA  = 8,
    parameter int                NB_OPS   = 6,
    parameter logic [NB_OPS-1:0] OP_RESET = 6'b100010
) (
    input logic               i_clk,
    input logic               i_reset,
    uart_alu_interface_if.slave bus
);

    typedef enum logic [1:0] {IDLE, WAIT_A, WAIT_B, WAIT_OP} state_t;

    localparam logic [NB_DATA-1:0] CMD_A    = NB_DATA'(8'h00);
    localparam logic [NB_DATA-1:0] CMD_B    = NB_DATA'(8'h01);
    localparam logic [NB_DATA-1:0] CMD_OP   = NB_DATA'(8'h02);
    localparam logic [NB_DATA-1:0] CMD_SEND = {NB_DATA{1'b1}};

    state_t             state, state_next;
    logic [NB_DATA-1:0] data_a_q, data_a_next;
    logic [NB_DATA-1:0] data_b_q, data_b_next;
    logic [NB_OPS-1:0]  ops_q, ops_next;
    logic [NB_DATA-1:0] tx_data_q, tx_data_next;
    logic               tx_valid_q, tx_valid_next;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state      <= IDLE;
            data_a_q   <= '0;
            data_b_q   <= '0;
            ops_q      <= OP_RESET;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            state      <= state_next;
            data_a_q   <= data_a_next;
            data_b_q   <= data_b_next;
            ops_q      <= ops_next;
            tx_data_q  <= tx_data_next;
            tx_valid_q <= tx_valid_next;
        end
    end

    // In the WAIT states every byte is payload, so 0x00..0x02/0xFF are only commands from IDLE.
    always_comb begin
        state_next    = state;
        data_a_next   = data_a_q;
        data_b_next   = data_b_q;
        ops_next      = ops_q;
        tx_data_next  = tx_data_q;
        tx_valid_next = 1'b0;
        if (bus.i_rx_valid) begin
            unique case (state)
                IDLE: begin
                    if (bus.i_rx_data == CMD_A) begin
                        state_next = WAIT_A;
                    end else if (bus.i_rx_data == CMD_B) begin
                        state_next = WAIT_B;
                    end else if (bus.i_rx_data == CMD_OP) begin
                        state_next = WAIT_OP;
                    end else if (bus.i_rx_data == CMD_SEND) begin
                        tx_data_next  = bus.i_res;
                        tx_valid_next = 1'b1;
                    end
                end
                WAIT_A: begin
                    data_a_next = bus.i_rx_data;
                    state_next  = IDLE;
                end
                WAIT_B: begin
                    data_b_next = bus.i_rx_data;
                    state_next  = IDLE;
                end
                WAIT_OP: begin
                    ops_next   = bus.i_rx_data[NB_OPS-1:0];
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign bus.o_data_a   = data_a_q;
    assign bus.o_data_b   = data_b_q;
    assign bus.o_ops      = ops_q;
    assign bus.o_tx_data  = tx_data_q;
    assign bus.o_tx_valid = tx_valid_q;

endmodule

// File: tb/tb_uart_alu_interface.sv
// Scoreboard bench for uart_alu_interface: a behavioural model predicts registers and
// queues the expected TX byte for every 0xFF command; a monitor pops on each TX strobe.
module tb_uart_alu_interface;

    localparam int NB_DATA = 8;
    localparam int NB_OPS  = 6;
    localparam logic [NB_OPS-1:0] OP_RESET = 6'b100010;

    logic clk;
    logic rst;
    int   checkCount = 0;
    int   failCount  = 0;

    uart_alu_interface_if #(.NB_DATA(NB_DATA), .NB_OPS(NB_OPS)) bus ();

    uart_alu_interface #(.NB_DATA(NB_DATA), .NB_OPS(NB_OPS), .OP_RESET(OP_RESET)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {M_IDLE, M_WA, M_WB, M_WO} mstate_t;
    mstate_t          modelState;
    logic [7:0]       expA, expB, expTx;
    logic [5:0]       expOps;
    logic [7:0]       txQueue[$];

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic modelReset();
        modelState = M_IDLE;
        expA = 8'h00; expB = 8'h00; expOps = OP_RESET; expTx = 8'h00;
    endtask

    // Drives one byte for the next rising edge; the caller decides whether valid drops after it.
    task automatic applyStimulus(input logic [7:0] b, input logic [7:0] r);
        @(posedge clk); #1;
        bus.i_rx_data  = b;
        bus.i_res      = r;
        bus.i_rx_valid = 1'b1;
        case (modelState)
            M_IDLE: begin
                if (b == 8'h00) modelState = M_WA;
                else if (b == 8'h01) modelState = M_WB;
                else if (b == 8'h02) modelState = M_WO;
                else if (b == 8'hFF) begin
                    txQueue.push_back(r);
                    expTx = r;
                end
            end
            M_WA: begin expA = b; modelState = M_IDLE; end
            M_WB: begin expB = b; modelState = M_IDLE; end
            M_WO: begin expOps = b[5:0]; modelState = M_IDLE; end
            default: modelState = M_IDLE;
        endcase
    endtask

    task automatic idleCycle();
        @(posedge clk); #1;
        bus.i_rx_valid = 1'b0;
    endtask

    task automatic checkRegs(input string tag);
        checkOutput({tag, "_a"},   bus.o_data_a,  expA);
        checkOutput({tag, "_b"},   bus.o_data_b,  expB);
        checkOutput({tag, "_ops"}, bus.o_ops,     expOps);
        checkOutput({tag, "_txd"}, bus.o_tx_data, expTx);
    endtask

    // Each strobe must match the oldest outstanding 0xFF command; a strobe with nothing queued is spurious.
    always @(negedge clk) begin
        if (!rst && bus.o_tx_valid) begin
            if (txQueue.size() == 0)
                checkOutput("tx_spurious", 32'd1, 32'd0);
            else
                checkOutput("tx_data", bus.o_tx_data, txQueue.pop_front());
        end
    end

    initial begin
        bus.i_rx_data  = '0;
        bus.i_rx_valid = 1'b0;
        bus.i_res      = '0;
        rst = 1'b1;
        modelReset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        checkRegs("reset");
        checkOutput("reset_txv", bus.o_tx_valid, 1'b0);

        applyStimulus(8'h01, 8'h00); applyStimulus(8'h0F, 8'h00); idleCycle();
        checkRegs("load_b");

        applyStimulus(8'h00, 8'h00); applyStimulus(8'hFF, 8'h00); idleCycle();
        checkRegs("load_a_ff");

        applyStimulus(8'hFF, 8'hF0); idleCycle();
        checkOutput("send_txv_high", bus.o_tx_valid, 1'b1);
        idleCycle();
        checkOutput("send_txv_low", bus.o_tx_valid, 1'b0);
        checkRegs("send");

        applyStimulus(8'h02, 8'h11); applyStimulus(8'hE0, 8'h11); idleCycle();
        checkRegs("ops_e0");

        applyStimulus(8'h02, 8'h22); applyStimulus(8'hFF, 8'h22); idleCycle();
        checkRegs("ops_ff");

        applyStimulus(8'h55, 8'h33); idleCycle(); idleCycle();
        checkRegs("unknown");

        // Back-to-back send commands followed immediately by a normal command.
        applyStimulus(8'hFF, 8'h3C); applyStimulus(8'hFF, 8'hC3);
        applyStimulus(8'h00, 8'h00); applyStimulus(8'h5A, 8'h00); idleCycle();
        checkRegs("b2b");

        applyStimulus(8'h00, 8'h00); idleCycle();
        #2 rst = 1'b1;
        modelReset();
        #3 rst = 1'b0;
        applyStimulus(8'h0F, 8'h00); idleCycle();
        checkRegs("mid_reset");

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) idleCycle();
            applyStimulus(($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 2)) :
                          (($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom)), 8'($urandom));
        end
        idleCycle(); idleCycle();
        checkRegs("random");

        idleCycle();
        checkOutput("sb_empty", txQueue.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
